// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the core front end: widths, opcodes and the
// fetch buffer entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b011_0011;
  localparam logic [6:0] OP_I_ALU  = 7'b001_0011;
  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Byte addresses are forced onto a word boundary before use.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(32'd3);
  endfunction

  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer for the fetch stage: DEPTH entries of {instr, pc} with
// flush, occupancy count and simultaneous push/pop.
module ifetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] EMPTY_C = (AW + 1)'(0);

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   wptr_r;
  logic [AW-1:0]   rptr_r;
  logic [AW:0]     cnt_r;
  logic            do_push_s;
  logic            do_pop_s;

  // A flush wins over both ports; a push into a full buffer is only legal
  // when the head leaves in the same cycle.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (flush) begin
      do_pop_s  = 1'b0;
      do_push_s = 1'b0;
    end else begin
      do_pop_s  = pop && (cnt_r != EMPTY_C);
      do_push_s = push && ((cnt_r != FULL_C) || do_pop_s);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r <= AW'(0);
      rptr_r <= AW'(0);
      cnt_r  <= EMPTY_C;
    end else if (flush) begin
      wptr_r <= AW'(0);
      rptr_r <= AW'(0);
      cnt_r  <= EMPTY_C;
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + (AW + 1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW + 1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Empty buffer presents a NOP at address zero.
  always_comb begin
    head_valid = (cnt_r != EMPTY_C);
    if (cnt_r != EMPTY_C) begin
      head = mem_r[rptr_r];
    end else begin
      head = '{instr: NOP_INSTR, pc: {XLEN{1'b0}}};
    end
    cnt = cnt_r;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order word fetches
// under a credit limit, buffers responses and handles redirects.
module ifetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ZERO_C    = CW'(0);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW:0]   CREDITS_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fpc_r;
  logic [XLEN-1:0] rpc_r;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   drop_r;

  logic [CW-1:0]   cnt_s;
  logic [CW:0]     occ_s;
  logic [XLEN-1:0] target_s;
  logic            accept_s;
  logic            rsp_s;
  logic            keep_s;
  logic            pop_s;
  logic [CW-1:0]   inflight_nx_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            head_valid_s;

  // Issue credit, response classification and next in-flight count.
  always_comb begin
    target_s       = word_align(PCTarget);
    occ_s          = {1'b0, inflight_r} + {1'b0, cnt_s};
    imem_req_valid = !PCSrc && (occ_s < CREDITS_C);
    imem_req_addr  = fpc_r;
    accept_s       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding cannot be ours; ignore it.
    rsp_s          = imem_rsp_valid && (inflight_r != ZERO_C);
    keep_s         = rsp_s && (drop_r == ZERO_C) && !PCSrc;
    pop_s          = head_valid_s && instr_ready && !PCSrc;
    push_entry_s   = '{instr: imem_rsp_data, pc: rpc_r};
    case ({accept_s, rsp_s})
      2'b10:   inflight_nx_s = inflight_r + ONE_C;
      2'b01:   inflight_nx_s = inflight_r - ONE_C;
      default: inflight_nx_s = inflight_r;
    endcase
  end

  // Fetch PC, response PC and outstanding/discard counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_r      <= RESET_PC;
      rpc_r      <= RESET_PC;
      inflight_r <= ZERO_C;
      drop_r     <= ZERO_C;
    end else begin
      inflight_r <= inflight_nx_s;
      if (PCSrc) begin
        // Everything still outstanding after this cycle is stale.
        fpc_r  <= target_s;
        rpc_r  <= target_s;
        drop_r <= inflight_nx_s;
      end else begin
        if (accept_s) begin
          fpc_r <= next_word(fpc_r);
        end
        if (keep_s) begin
          rpc_r <= next_word(rpc_r);
        end
        if (rsp_s && (drop_r != ZERO_C)) begin
          drop_r <= drop_r - ONE_C;
        end
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (PCSrc),
    .push       (keep_s),
    .wdata      (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .head_valid (head_valid_s),
    .cnt        (cnt_s)
  );

  // Decode-facing fields come straight from the registered buffer head.
  always_comb begin
    instr_valid = head_valid_s;
    instr       = head_s.instr;
    pc          = head_s.pc;
    pc_plus4    = next_word(head_s.pc);
    op          = head_s.instr[6:0];
    funct3      = head_s.instr[14:12];
    funct7      = head_s.instr[30];
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: latency-configurable memory model plus an
// architectural expected-PC scoreboard for randomized runs.
module tb_ifetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;

  always #5 clk = ~clk;

  ifetch #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .op(op), .funct3(funct3), .funct7(funct7)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k = 1;

  typedef struct { logic [31:0] a; int t; } req_t;
  req_t mq[$];

  logic        rst_v = 1'b1, pcsrc_v = 1'b0, rdy_v = 1'b1, ird_v = 1'b1;
  logic [31:0] tgt_v = 32'h0;

  logic        o_rv, o_acc, o_rsp, o_iv, o_pop, o_f7;
  logic [31:0] o_ra, o_instr, o_pc, o_pc4;
  logic [6:0]  o_op;
  logic [2:0]  o_f3;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later, update memory.
  task automatic step();
    @(negedge clk);
    reset = rst_v; PCSrc = pcsrc_v; PCTarget = tgt_v;
    imem_req_ready = rdy_v; instr_ready = ird_v;
    if (rst_v) mq.delete();
    if (!rst_v && mq.size() > 0 && (mq[0].t + k <= cyc)) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = memw(mq[0].a);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'hDEAD_BEEF;
    end
    #1;
    o_rv = imem_req_valid; o_ra = imem_req_addr;
    o_acc = !rst_v && imem_req_valid && imem_req_ready;
    o_rsp = imem_rsp_valid; o_iv = instr_valid; o_instr = instr;
    o_pc = pc; o_pc4 = pc_plus4; o_op = op; o_f3 = funct3; o_f7 = funct7;
    o_pop = !rst_v && instr_valid && instr_ready && !PCSrc;
    if (o_rsp) mq.delete(0);
    if (o_acc) mq.push_back('{a: imem_req_addr, t: cyc});
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1; pcsrc_v = 1'b0; rdy_v = 1'b1; ird_v = 1'b1;
    step(); step();
    rst_v = 1'b0;
  endtask

  task automatic test_reset();
    rst_v = 1'b1; step(); step();
    checks++; if (o_iv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_iv); end
    checks++; if (o_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", o_instr, NOP); end
    checks++; if (o_pc !== 32'h0 || o_pc4 !== 32'h4) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0/4", o_pc, o_pc4); end
    checks++; if (o_ra !== RESET_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", o_ra, RESET_PC); end
    rst_v = 1'b0;
  endtask

  task automatic test_fetch_order();
    logic [31:0] accq[$];
    logic [31:0] w;
    int first_req = -1, first_iv = -1;
    logic [31:0] iv_pc = 32'h0, iv_pc4 = 32'h0, iv_instr = 32'h0;
    logic [6:0] iv_op = 7'h0;
    k = 1; rdy_v = 1'b1; ird_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_acc) begin
        accq.push_back(o_ra);
        if (first_req < 0) first_req = i;
      end
      if (o_iv && first_iv < 0) begin
        first_iv = i; iv_pc = o_pc; iv_pc4 = o_pc4; iv_instr = o_instr; iv_op = o_op;
      end
    end
    w = memw(32'h0);
    checks++; if (first_req !== 0) begin failures++; $display("FAIL first_req_cycle got=%0d exp=0", first_req); end
    checks++; if (accq.size() < 3) begin failures++; $display("FAIL req_count got=%0d exp>=3", accq.size()); end
    else if (accq[0] !== 32'h0 || accq[1] !== 32'h4 || accq[2] !== 32'h8) begin
      failures++; $display("FAIL req_order got=%h,%h,%h exp=0,4,8", accq[0], accq[1], accq[2]);
    end
    checks++; if (first_iv - first_req !== 2) begin failures++; $display("FAIL first_iv_latency got=%0d exp=2", first_iv - first_req); end
    checks++; if (iv_pc !== 32'h0 || iv_pc4 !== 32'h4) begin failures++; $display("FAIL first_pc got=%h/%h exp=0/4", iv_pc, iv_pc4); end
    checks++; if (iv_instr !== w || iv_op !== w[6:0]) begin failures++; $display("FAIL first_instr got=%h op=%h exp=%h", iv_instr, iv_op, w); end
  endtask

  task automatic test_stall();
    int nacc = 0;
    do_reset(); k = 1; ird_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); if (o_acc) nacc++;
    end
    checks++; if (nacc !== 2) begin failures++; $display("FAIL stall_accepts got=%0d exp=2", nacc); end
    checks++; if (o_rv !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", o_rv); end
    checks++; if (o_iv !== 1'b1 || o_pc !== 32'h0) begin failures++; $display("FAIL stall_head got=%b/%h exp=1/0", o_iv, o_pc); end
    ird_v = 1'b1; step();
    checks++; if (o_pop !== 1'b1 || o_rv !== 1'b0) begin failures++; $display("FAIL stall_pop got=%b rv=%b exp=1/0", o_pop, o_rv); end
    ird_v = 1'b0; step();
    checks++; if (o_rv !== 1'b1 || o_ra !== 32'h8) begin failures++; $display("FAIL stall_resume got=%b/%h exp=1/8", o_rv, o_ra); end
    checks++; if (o_pc !== 32'h4) begin failures++; $display("FAIL stall_next_pc got=%h exp=4", o_pc); end
  endtask

  task automatic test_redirect();
    bit found = 0;
    do_reset(); k = 3; ird_v = 1'b1;
    step(); step();
    checks++; if (mq.size() !== 2) begin failures++; $display("FAIL redir_inflight got=%0d exp=2", mq.size()); end
    pcsrc_v = 1'b1; tgt_v = 32'h0000_0103; step();
    checks++; if (o_rv !== 1'b0) begin failures++; $display("FAIL redir_no_issue got=%b exp=0", o_rv); end
    pcsrc_v = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (o_iv) begin
        found = 1;
        checks++; if (o_pc !== 32'h100 || o_instr !== memw(32'h100)) begin
          failures++; $display("FAIL redir_first_pc got=%h/%h exp=100/%h", o_pc, o_instr, memw(32'h100));
        end
      end
    end
    if (!found) begin checks++; failures++; $display("FAIL redir_timeout got=none exp=instr_valid"); end
  endtask

  task automatic test_redirect_rsp_pop();
    bit found = 0;
    do_reset(); k = 1; ird_v = 1'b0;
    step(); step();
    pcsrc_v = 1'b1; tgt_v = 32'h0000_0200; ird_v = 1'b1; step();
    checks++; if (o_rsp !== 1'b1 || o_iv !== 1'b1) begin failures++; $display("FAIL rsp_pop_setup got=%b/%b exp=1/1", o_rsp, o_iv); end
    pcsrc_v = 1'b0; ird_v = 1'b0; step();
    checks++; if (o_iv !== 1'b0 || o_instr !== NOP || o_pc !== 32'h0) begin
      failures++; $display("FAIL rsp_pop_empty got=%b/%h/%h exp=0/%h/0", o_iv, o_instr, o_pc, NOP);
    end
    checks++; if (o_rv !== 1'b1 || o_ra !== 32'h200) begin failures++; $display("FAIL rsp_pop_req got=%b/%h exp=1/200", o_rv, o_ra); end
    ird_v = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (o_iv) begin
        found = 1;
        checks++; if (o_pc !== 32'h200) begin failures++; $display("FAIL rsp_pop_next got=%h exp=200", o_pc); end
      end
    end
    if (!found) begin checks++; failures++; $display("FAIL rsp_pop_timeout got=none exp=instr_valid"); end
  endtask

  task automatic test_async_reset();
    do_reset(); k = 1; ird_v = 1'b0;
    step(); step(); step(); step();
    checks++; if (o_iv !== 1'b1) begin failures++; $display("FAIL areset_setup got=%b exp=1", o_iv); end
    @(negedge clk); #3; reset = 1'b1; #1;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP || pc !== 32'h0) begin
      failures++; $display("FAIL areset_outputs got=%b/%h/%h exp=0/%h/0", instr_valid, instr, pc, NOP);
    end
    checks++; if (imem_req_addr !== RESET_PC) begin failures++; $display("FAIL areset_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    mq.delete(); rst_v = 1'b1; step(); rst_v = 1'b0; ird_v = 1'b1; step();
    checks++; if (o_acc !== 1'b1 || o_ra !== RESET_PC) begin failures++; $display("FAIL areset_first_req got=%b/%h exp=1/%h", o_acc, o_ra, RESET_PC); end
  endtask

  task automatic test_wrap();
    int base;
    bit found = 0;
    do_reset(); k = 1; ird_v = 1'b1;
    step();
    pcsrc_v = 1'b1; tgt_v = 32'hFFFF_FFFC; step();
    pcsrc_v = 1'b0; base = cyc;
    step();
    checks++; if (o_acc !== 1'b1 || o_ra !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffffc", o_acc, o_ra); end
    step();
    checks++; if (o_acc !== 1'b1 || o_ra !== 32'h0) begin failures++; $display("FAIL wrap_req1 got=%b/%h exp=1/0", o_acc, o_ra); end
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (o_iv) begin
        found = 1;
        checks++; if (cyc - base !== 2 + k) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", cyc - base, 2 + k); end
        checks++; if (o_pc !== 32'hFFFF_FFFC || o_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h/%h exp=fffffffc/0", o_pc, o_pc4); end
      end
    end
    if (!found) begin checks++; failures++; $display("FAIL wrap_timeout got=none exp=instr_valid"); end
  endtask

  // Expected stream: sequential from reset or from each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] w;
    int npop;
    for (int r = 0; r < 4; r++) begin
      do_reset(); k = $urandom_range(1, 4); exp_pc = RESET_PC; npop = 0;
      for (int i = 0; i < 400; i++) begin
        rdy_v   = ($urandom_range(0, 3) != 0);
        ird_v   = ($urandom_range(0, 9) < 7);
        pcsrc_v = ($urandom_range(0, 19) == 0);
        tgt_v   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        step();
        if (pcsrc_v) begin
          exp_pc = tgt_v & ~32'd3;
          checks++; if (o_rv !== 1'b0) begin failures++; $display("FAIL rand_redir_issue got=%b exp=0", o_rv); end
        end else if (o_pop) begin
          w = memw(exp_pc); npop++;
          checks++; if (o_pc !== exp_pc || o_pc4 !== exp_pc + 32'd4) begin
            failures++; $display("FAIL rand_pc got=%h/%h exp=%h", o_pc, o_pc4, exp_pc);
          end
          checks++; if (o_instr !== w || o_op !== w[6:0] || o_f3 !== w[14:12] || o_f7 !== w[30]) begin
            failures++; $display("FAIL rand_instr got=%h exp=%h", o_instr, w);
          end
          exp_pc = exp_pc + 32'd4;
        end
        if (!o_iv) begin
          checks++; if (o_instr !== NOP || o_pc !== 32'h0) begin failures++; $display("FAIL rand_empty got=%h/%h exp=%h/0", o_instr, o_pc, NOP); end
        end
        checks++; if (mq.size() > DEPTH) begin failures++; $display("FAIL rand_credit got=%0d exp<=%0d", mq.size(), DEPTH); end
      end
      pcsrc_v = 1'b0;
      checks++; if (npop < 20) begin failures++; $display("FAIL rand_progress got=%0d exp>=20", npop); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_order();
    test_stall();
    test_redirect();
    test_redirect_rsp_pop();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
